// File: rtl/tester_pkg.sv
// Shared definitions for the vector sequencer and its cycle timer.
//   seq_state_e : sequencer control states
//   FF_*        : 2-bit force-format codes applied per pin
//   FF_RESET    : force format held by every pin out of reset (drive 0)
package tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_RUN   = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } seq_state_e;

   localparam logic [1:0] FF_R0     = 2'b00;
   localparam logic [1:0] FF_R1     = 2'b01;
   localparam logic [1:0] FF_DNRZ_L = 2'b10;
   localparam logic [1:0] FF_DNRZ_T = 2'b11;

   localparam logic [1:0] FF_RESET  = FF_R0;

endpackage

// File: rtl/cycle_timer.sv
// Tester-cycle timer: period counter and CYCLE waveform generation.
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : advance the counter (otherwise counter and CYCLE clear)
//   preload      : load counter with period-1 (setup clock, CYCLE low)
//   period,trail : tester cycle length and trailing-edge count position
//   cycle        : registered CYCLE waveform, high for counts [0, trail-1]
//   apply_pt     : next clock the counter becomes period-1
//   wrap_pt      : next clock the counter wraps to 0 (leading edge)
module cycle_timer
   import tester_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             preload,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] trail,
   output logic             cycle,
   output logic             apply_pt,
   output logic             wrap_pt
);

   logic [CNT_W-1:0] pcnt_r;
   logic [CNT_W-1:0] pcnt_nxt_s;
   logic [CNT_W:0]   inc1_s;
   logic [CNT_W:0]   inc2_s;
   logic             cycle_r;

   // Strobes come from the current count only, so the sequencer can use them
   // to decide the timer enable without a combinational loop.
   always_comb begin
      inc1_s   = {1'b0, pcnt_r} + (CNT_W+1)'(1);
      inc2_s   = {1'b0, pcnt_r} + (CNT_W+1)'(2);
      wrap_pt  = (inc1_s == {1'b0, period});
      apply_pt = (inc2_s == {1'b0, period});
      if (wrap_pt) begin
         pcnt_nxt_s = '0;
      end else begin
         pcnt_nxt_s = inc1_s[CNT_W-1:0];
      end
   end

   // Counter and CYCLE register; CYCLE is decoded from the next count so it
   // lines up with the counter value it describes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_r  <= '0;
         cycle_r <= 1'b0;
      end else if (preload) begin
         pcnt_r  <= period - CNT_W'(1);
         cycle_r <= 1'b0;
      end else if (enable) begin
         pcnt_r  <= pcnt_nxt_s;
         cycle_r <= (pcnt_nxt_s < trail);
      end else begin
         pcnt_r  <= '0;
         cycle_r <= 1'b0;
      end
   end

   assign cycle = cycle_r;

endmodule

// File: rtl/vector_sequencer.sv
// Pattern controller for a bank of force-format pin registers.
//   CLK, RST_N            : clock, asynchronous active-low reset
//   START, ABORT          : begin a run (IDLE only) / stop a run or clear error
//   PERIOD, TRAIL, NUM_VEC: run configuration, latched at START
//   VEC_DATA, VEC_FF      : upstream vector (pin data, 2-bit format per pin)
//   VEC_VALID, VEC_READY  : upstream handshake into a one-entry buffer
//   CYCLE                 : tester cycle waveform
//   D, FF, VEC_IDX        : applied vector and its index
//   BUSY, DONE            : run in progress / one-clock completion pulse
//   UNDERRUN, CFG_ERR     : sticky underrun flag / rejected-START pulse
module vector_sequencer
   import tester_pkg::*;
#(
   parameter int NPINS = 8,
   parameter int CNT_W = 8,
   parameter int VEC_W = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic               ABORT,
   input  logic [CNT_W-1:0]   PERIOD,
   input  logic [CNT_W-1:0]   TRAIL,
   input  logic [VEC_W-1:0]   NUM_VEC,
   input  logic [NPINS-1:0]   VEC_DATA,
   input  logic [2*NPINS-1:0] VEC_FF,
   input  logic               VEC_VALID,
   output logic               VEC_READY,
   output logic               CYCLE,
   output logic [NPINS-1:0]   D,
   output logic [2*NPINS-1:0] FF,
   output logic [VEC_W-1:0]   VEC_IDX,
   output logic               BUSY,
   output logic               DONE,
   output logic               UNDERRUN,
   output logic               CFG_ERR
);

   seq_state_e         state_r, state_nxt_s;

   logic [CNT_W-1:0]   period_r, trail_r;
   logic [VEC_W-1:0]   num_vec_r, vec_idx_r;
   logic               buf_full_r;
   logic [NPINS-1:0]   buf_d_r, d_r;
   logic [2*NPINS-1:0] buf_ff_r, ff_r;
   logic               fin_r, busy_r, done_r, underrun_r, cfg_err_r;

   logic cfg_ok_s, last_s, accept_s, vec_ready_s;
   logic load_cfg_s, cfg_err_nxt_s, first_s, apply_s, flush_s, set_fin_s;
   logic ur_set_s, ur_clr_s, done_nxt_s, tmr_en_s, tmr_pre_s;
   logic apply_pt_s, wrap_pt_s, cycle_s;

   assign cfg_ok_s    = (PERIOD >= CNT_W'(2)) && (TRAIL != '0) &&
                        (TRAIL < PERIOD) && (NUM_VEC != '0);
   assign last_s      = (({1'b0, vec_idx_r} + (VEC_W+1)'(1)) == {1'b0, num_vec_r});
   assign vec_ready_s = !buf_full_r && ((state_r == ST_FETCH) || (state_r == ST_RUN));
   assign accept_s    = VEC_VALID && vec_ready_s;

   cycle_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (CLK),
      .rst_n    (RST_N),
      .enable   (tmr_en_s),
      .preload  (tmr_pre_s),
      .period   (period_r),
      .trail    (trail_r),
      .cycle    (cycle_s),
      .apply_pt (apply_pt_s),
      .wrap_pt  (wrap_pt_s)
   );

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and control decode; ABORT outranks every other event.
   always_comb begin
      state_nxt_s   = state_r;
      load_cfg_s    = 1'b0;
      cfg_err_nxt_s = 1'b0;
      first_s       = 1'b0;
      apply_s       = 1'b0;
      flush_s       = 1'b0;
      set_fin_s     = 1'b0;
      ur_set_s      = 1'b0;
      ur_clr_s      = 1'b0;
      done_nxt_s    = 1'b0;
      tmr_en_s      = 1'b0;
      tmr_pre_s     = 1'b0;
      if (ABORT && (state_r != ST_IDLE)) begin
         state_nxt_s = ST_IDLE;
         flush_s     = 1'b1;
         ur_clr_s    = 1'b1;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (START && cfg_ok_s) begin
                  load_cfg_s  = 1'b1;
                  state_nxt_s = ST_FETCH;
               end else if (START) begin
                  cfg_err_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_FETCH: begin
               if (buf_full_r) begin
                  first_s     = 1'b1;
                  tmr_pre_s   = 1'b1;
                  state_nxt_s = ST_RUN;
               end else begin
                  state_nxt_s = ST_FETCH;
               end
            end
            ST_RUN: begin
               // fin_r marks that the last vector's apply point has passed,
               // so the next wrap ends its period instead of starting one.
               if (wrap_pt_s && fin_r) begin
                  state_nxt_s = ST_DONE;
                  done_nxt_s  = 1'b1;
               end else if (apply_pt_s && last_s) begin
                  set_fin_s = 1'b1;
                  tmr_en_s  = 1'b1;
               end else if (apply_pt_s && buf_full_r) begin
                  apply_s  = 1'b1;
                  tmr_en_s = 1'b1;
               end else if (apply_pt_s) begin
                  ur_set_s    = 1'b1;
                  state_nxt_s = ST_ERR;
               end else begin
                  tmr_en_s = 1'b1;
               end
            end
            ST_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            ST_ERR: begin
               state_nxt_s = ST_ERR;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // Configuration, vector buffer, applied vector and status registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         period_r   <= '0;
         trail_r    <= '0;
         num_vec_r  <= '0;
         buf_full_r <= 1'b0;
         buf_d_r    <= '0;
         buf_ff_r   <= {NPINS{FF_RESET}};
         d_r        <= '0;
         ff_r       <= {NPINS{FF_RESET}};
         vec_idx_r  <= '0;
         fin_r      <= 1'b0;
         underrun_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         cfg_err_r  <= 1'b0;
      end else begin
         if (load_cfg_s) begin
            period_r  <= PERIOD;
            trail_r   <= TRAIL;
            num_vec_r <= NUM_VEC;
         end
         if (flush_s || first_s || apply_s) begin
            buf_full_r <= 1'b0;
         end else if (accept_s) begin
            buf_full_r <= 1'b1;
         end
         if (accept_s) begin
            buf_d_r  <= VEC_DATA;
            buf_ff_r <= VEC_FF;
         end
         if (first_s || apply_s) begin
            d_r  <= buf_d_r;
            ff_r <= buf_ff_r;
         end
         if (first_s) begin
            vec_idx_r <= '0;
         end else if (apply_s) begin
            vec_idx_r <= vec_idx_r + VEC_W'(1);
         end
         if (load_cfg_s) begin
            fin_r <= 1'b0;
         end else if (set_fin_s) begin
            fin_r <= 1'b1;
         end
         if (ur_clr_s) begin
            underrun_r <= 1'b0;
         end else if (ur_set_s) begin
            underrun_r <= 1'b1;
         end
         busy_r    <= (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_RUN);
         done_r    <= done_nxt_s;
         cfg_err_r <= cfg_err_nxt_s;
      end
   end

   assign VEC_READY = vec_ready_s;
   assign CYCLE     = cycle_s;
   assign D         = d_r;
   assign FF        = ff_r;
   assign VEC_IDX   = vec_idx_r;
   assign BUSY      = busy_r;
   assign DONE      = done_r;
   assign UNDERRUN  = underrun_r;
   assign CFG_ERR   = cfg_err_r;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: random vectors, a queue of
// expected applied vectors checked at every CYCLE rise, plus directed
// checks for timing, underrun, bad configuration, abort and reset.
module tb_vector_sequencer;
   import tester_pkg::*;

   typedef struct {
      logic [7:0]  d;
      logic [15:0] ff;
      logic [15:0] idx;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [7:0]  period, trail;
   logic [15:0] num_vec;
   logic [7:0]  vec_data;
   logic [15:0] vec_ff;
   logic        vec_valid, vec_ready, cycle, busy, done, underrun, cfg_err;
   logic [7:0]  d;
   logic [15:0] ff, vec_idx;

   int n_chk = 0;
   int n_err = 0;
   exp_t exp_q[$];
   int mdl_period = 0;
   int mdl_trail  = 0;
   int hs_cnt = 0;
   int run_base = 0;
   int src_limit = 0;
   logic [7:0]  src_d  [16];
   logic [15:0] src_ff [16];

   vector_sequencer #(.NPINS(8), .CNT_W(8), .VEC_W(16)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort),
      .PERIOD(period), .TRAIL(trail), .NUM_VEC(num_vec),
      .VEC_DATA(vec_data), .VEC_FF(vec_ff), .VEC_VALID(vec_valid),
      .VEC_READY(vec_ready), .CYCLE(cycle), .D(d), .FF(ff),
      .VEC_IDX(vec_idx), .BUSY(busy), .DONE(done),
      .UNDERRUN(underrun), .CFG_ERR(cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rand_ff();
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            32'd0:   r[2*i +: 2] = FF_R0;
            32'd1:   r[2*i +: 2] = FF_R1;
            32'd2:   r[2*i +: 2] = FF_DNRZ_L;
            default: r[2*i +: 2] = FF_DNRZ_T;
         endcase
      end
      return r;
   endfunction

   // Upstream source: offers src entries [0, src_limit) of the current run.
   initial begin
      int  idx;
      bit  hs;
      vec_valid = 1'b0;
      vec_data  = 8'h00;
      vec_ff    = 16'h0000;
      forever begin
         @(negedge clk);
         hs = vec_valid && vec_ready && rst_n;
         @(posedge clk);
         #2;
         if (hs) hs_cnt++;
         idx = hs_cnt - run_base;
         if (idx >= 0 && idx < src_limit && idx < 16) begin
            vec_valid = 1'b1;
            vec_data  = src_d[idx[3:0]];
            vec_ff    = src_ff[idx[3:0]];
         end else begin
            vec_valid = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard at every CYCLE rise, checks waveform shape.
   initial begin
      bit          prev_cyc = 1'b0;
      bit          rise_seen = 1'b0;
      int          hi_len = 0;
      int          cyc_cnt = 0;
      int          last_rise = 0;
      logic [7:0]  d_hold = 8'h00;
      logic [15:0] ff_hold = 16'h0000;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_cyc  = 1'b0;
            rise_seen = 1'b0;
            hi_len    = 0;
         end else begin
            cyc_cnt++;
            if (cycle && !prev_cyc) begin
               if (exp_q.size() == 0) begin
                  chk("extra_rise", 32'(vec_idx), 32'hFFFF_FFFF);
               end else begin
                  e = exp_q.pop_front();
                  chk("rise_d", 32'(d), 32'(e.d));
                  chk("rise_ff", 32'(ff), 32'(e.ff));
                  chk("rise_idx", 32'(vec_idx), 32'(e.idx));
               end
               if (rise_seen) chk("period", 32'(cyc_cnt - last_rise), 32'(mdl_period));
               rise_seen = 1'b1;
               last_rise = cyc_cnt;
               hi_len    = 1;
               d_hold    = d;
               ff_hold   = ff;
            end else if (cycle) begin
               hi_len++;
               chk("d_stable_high", 32'({d, ff}), 32'({d_hold, ff_hold}));
            end else if (prev_cyc && busy) begin
               chk("high_len", 32'(hi_len), 32'(mdl_trail));
            end
            if (!busy) rise_seen = 1'b0;
            if (done) chk("done_all_rises", 32'(exp_q.size()), 32'd0);
            prev_cyc = cycle;
         end
      end
   end

   task automatic setup_run(input int p, input int t, input int n, input int limit, input int npush);
      for (int i = 0; i < 16; i++) begin
         src_d[i[3:0]]  = 8'($urandom);
         src_ff[i[3:0]] = rand_ff();
      end
      run_base   = hs_cnt;
      src_limit  = limit;
      mdl_period = p;
      mdl_trail  = t;
      exp_q.delete();
      for (int i = 0; i < npush; i++) begin
         exp_q.push_back('{d: src_d[i[3:0]], ff: src_ff[i[3:0]], idx: 16'(i)});
      end
      period  = 8'(p);
      trail   = 8'(t);
      num_vec = 16'(n);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic do_run(input int p, input int t, input int n);
      int done_at;
      setup_run(p, t, n, n, n);
      pulse_start();
      done_at = -1;
      for (int k = 1; k <= n * p + 20; k++) begin
         @(negedge clk);
         if (done) begin
            done_at = k - 1;
            break;
         end
      end
      chk("done_time", 32'(done_at), 32'(3 + n * p));
      @(negedge clk);
      chk("done_one_clk", 32'(done), 32'd0);
      chk("d_hold_last", 32'(d), 32'(src_d[4'(n - 1)]));
      chk("ff_hold_last", 32'(ff), 32'(src_ff[4'(n - 1)]));
      chk("no_underrun", 32'(underrun), 32'd0);
      chk("idle_not_busy", 32'(busy), 32'd0);
      exp_q.delete();
   endtask

   task automatic cfg_bad(input int p, input int t, input int n);
      setup_run(p, t, n, 0, 0);
      pulse_start();
      @(negedge clk);
      chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
      chk("cfg_err_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("cfg_err_one_clk", 32'(cfg_err), 32'd0);
      chk("cfg_err_cycle", 32'(cycle), 32'd0);
      chk("cfg_err_still_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int p, t, n, ur_at, found;
      logic [7:0]  d_sv;
      logic [15:0] ff_sv;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      period = 8'd0; trail = 8'd0; num_vec = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_cycle", 32'(cycle), 32'd0);
      chk("rst_d", 32'(d), 32'd0);
      chk("rst_ff", 32'(ff), 32'd0);
      chk("rst_idx", 32'(vec_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_flags", 32'({done, underrun, cfg_err}), 32'd0);
      chk("rst_ready", 32'(vec_ready), 32'd0);
      rst_n = 1'b1;

      do_run(4, 2, 3);
      do_run(2, 1, 8);
      do_run(3, 2, 1);
      repeat (6) begin
         p = $urandom_range(2, 7);
         t = $urandom_range(1, p - 1);
         n = $urandom_range(1, 6);
         do_run(p, t, n);
      end

      // Underrun: only vector A is ever offered.
      setup_run(4, 2, 3, 1, 1);
      pulse_start();
      ur_at = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (underrun) begin
            ur_at = k - 1;
            break;
         end
      end
      chk("underrun_time", 32'(ur_at), 32'd6);
      chk("underrun_cycle", 32'(cycle), 32'd0);
      chk("underrun_d_hold", 32'(d), 32'(src_d[0]));
      chk("underrun_ready", 32'(vec_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("underrun_sticky", 32'(underrun), 32'd1);
      chk("err_cycle_low", 32'(cycle), 32'd0);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_clears_ur", 32'(underrun), 32'd0);
      chk("abort_err_busy", 32'(busy), 32'd0);
      chk("abort_err_d", 32'(d), 32'(src_d[0]));
      chk("underrun_rises", 32'(exp_q.size()), 32'd0);

      cfg_bad(4, 0, 3);
      cfg_bad(4, 4, 3);
      cfg_bad(1, 1, 3);
      cfg_bad(4, 2, 0);

      // Abort while CYCLE is high for vector 1 of 5.
      setup_run(5, 3, 5, 5, 5);
      pulse_start();
      found = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (cycle && vec_idx == 16'd1) begin
            found = 1;
            break;
         end
      end
      chk("abort_found_vec1", 32'(found), 32'd1);
      d_sv  = d;
      ff_sv = ff;
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      exp_q.delete();
      chk("abort_cycle", 32'(cycle), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(vec_ready), 32'd0);
      chk("abort_d_hold", 32'(d), 32'(d_sv));
      chk("abort_ff_hold", 32'(ff), 32'(ff_sv));
      do_run(3, 1, 2);

      // Asynchronous reset in the middle of a run.
      setup_run(3, 2, 6, 6, 6);
      pulse_start();
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_cycle", 32'(cycle), 32'd0);
      chk("arst_d", 32'(d), 32'd0);
      chk("arst_ff", 32'(ff), 32'd0);
      chk("arst_idx", 32'(vec_idx), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_flags", 32'({done, underrun, cfg_err, vec_ready}), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      do_run(3, 2, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
- Pattern controller for a bank of NPINS force-format pin registers.
- Generates the tester CYCLE waveform (leading and trailing edges) from a programmable period and trailing-edge position.
- Pulls one vector per tester cycle (pin data plus 2-bit force format per pin) from an upstream valid/ready source and presents it as registered D/FF buses to the pin registers.
- Runs a programmed number of vectors, then signals completion; detects vector-stream underrun and bad configuration.

Parameters:
- NPINS, 8, number of pins driven.
- CNT_W, 8, width of PERIOD/TRAIL and the period counter.
- VEC_W, 16, width of NUM_VEC and VEC_IDX.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  begin a run; sampled in IDLE only.
- ABORT  in  1  stop a run or clear an error.
- PERIOD  in  CNT_W  tester cycle length in CLK cycles; latched at START.
- TRAIL  in  CNT_W  trailing-edge count position; latched at START.
- NUM_VEC  in  VEC_W  vectors per run; latched at START.
- VEC_DATA  in  NPINS  vector pin data.
- VEC_FF  in  2*NPINS  vector force formats; pin i uses bits [2i+1:2i].
- VEC_VALID  in  1  upstream vector valid.
- VEC_READY  out  1  one-entry buffer empty and the block is in FETCH or RUN.
- CYCLE  out  1  tester cycle waveform.
- D  out  NPINS  applied pin data.
- FF  out  2*NPINS  applied force formats.
- VEC_IDX  out  VEC_W  index of the currently applied vector.
- BUSY  out  1  high in FETCH/RUN.
- DONE  out  1  one-CLK pulse when a run completes.
- UNDERRUN  out  1  sticky; buffer empty at an apply point.
- CFG_ERR  out  1  one-CLK pulse when START is rejected.

Behaviour:
- Reset values: all outputs 0 (FF = 00 = R0 on every pin, so pins drive 0). State IDLE, buffer empty, counter 0.
- All outputs are registered except VEC_READY, which is decoded from state and buffer flag.
- States: IDLE, FETCH, RUN, DONE, ERR.
- IDLE, START=1:
  - Config valid when PERIOD>=2, 1<=TRAIL<=PERIOD-1 and NUM_VEC>=1.
  - Valid: latch config, go to FETCH.
  - Invalid: pulse CFG_ERR, stay in IDLE.
- Handshake: a vector is accepted into the one-entry buffer when VEC_VALID && VEC_READY. The buffer is emptied only at an apply point.
- FETCH: once the buffer is full, the next clock:
  - D/FF <= buffer, buffer emptied, VEC_IDX <= 0;
  - state RUN, period counter PCNT <= PERIOD-1 (setup clock, CYCLE=0).
- RUN:
  - PCNT counts 0..PERIOD-1 and wraps.
  - CYCLE=1 for PCNT in [0, TRAIL-1] and CYCLE=0 for PCNT in [TRAIL, PERIOD-1]. The leading edge is the rise at PCNT=0; the trailing edge is the fall at PCNT=TRAIL.
- Apply point: the clock on which PCNT becomes PERIOD-1 (CYCLE low, one CLK before the next leading edge).
  - If VEC_IDX < NUM_VEC-1: D/FF <= buffer, VEC_IDX++, buffer emptied.
  - If the buffer is empty: UNDERRUN <= 1, go to ERR. This holds even if VEC_VALID is high on that same clock (no bypass).
  - If VEC_IDX == NUM_VEC-1: no apply. When PCNT would wrap to 0, go to DONE; no further CYCLE pulse.
- A run therefore produces exactly NUM_VEC CYCLE pulses. D/FF never change while CYCLE is high or at a CYCLE edge.
- DONE: DONE=1 for one CLK, then IDLE. D/FF hold their last values.
- ERR: CYCLE=0, D/FF hold, VEC_READY=0, UNDERRUN held. Leaves only on ABORT.
- ABORT in any non-IDLE state: next clock IDLE, CYCLE=0, buffer flushed, UNDERRUN cleared, D/FF hold. ABORT has priority over every other event in the same clock.
- START outside IDLE is ignored.
- RST_N low mid-run: immediately returns to reset values.
- PCNT width CNT_W; no arithmetic beyond compare and increment. VEC_IDX never exceeds NUM_VEC-1.

Decomposition:
- Package tester_pkg:
  - state enum;
  - force-format constants R0=00, R1=01, DNRZ_L=10, DNRZ_T=11;
  - FF reset value R0.
- One sub-module, cycle_timer:
  - PCNT, CYCLE generation, apply-point and wrap strobes;
  - inputs: enable, preload, PERIOD, TRAIL.

Test Plan:
- PERIOD=4, TRAIL=2, NUM_VEC=3, VEC_VALID=1 with vectors A/B/C -> CYCLE = 1100 repeated 3 times after a 1-CLK setup. D/FF become B then C on the clock PCNT becomes 3. VEC_IDX 0,1,2. DONE pulses one CLK after the third period ends. Exactly 3 CYCLE rises.
- Same config, VEC_VALID dropped after vector A -> UNDERRUN=1 on the clock PCNT becomes 3 of vector 0, CYCLE stays 0, D holds A. ABORT then returns to IDLE with UNDERRUN=0.
- START with TRAIL=0, TRAIL=PERIOD, PERIOD=1 or NUM_VEC=0 -> CFG_ERR one-CLK pulse each time, BUSY stays 0, CYCLE stays 0.
- ABORT while CYCLE=1 in vector 1 of 5 -> next clock IDLE, CYCLE=0, BUSY=0, VEC_READY=0, D/FF unchanged.
- RST_N pulsed low mid-RUN -> CYCLE, D, FF, VEC_IDX, BUSY and flags go to 0 asynchronously. After release, START runs normally.
- PERIOD=2, TRAIL=1, NUM_VEC=8, VEC_VALID=1 -> CYCLE toggles 10 every period, no UNDERRUN, 8 CYCLE rises, VEC_READY deasserts exactly one clock per vector.
